// File: rtl/alu_stim_driver.sv
// alu_stim_driver
//   Transaction-level driver for the serial ALU operand interface. Takes one
//   command (op, A, B) per cmd handshake, serialises it to the ALU over two
//   cycles (A with op[0], then B with op[1]), then waits for done. The
//   captured result/overflow is returned on the rsp channel together with a
//   golden-model comparison and a timeout flag.
//
// Ports
//   clk, reset_n           clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b   00 add, 01 sub, 10 xor, 11 xnor; operands
//   opcode_valid, opcode,  serial operand interface to the ALU
//   data
//   result, overflow, done ALU response
//   rsp_valid/rsp_ready    response handshake, fields held until accepted
//   rsp_result, rsp_overflow, rsp_timeout, rsp_mismatch
//   protocol_err           1-cycle pulse when done arrives outside WAIT_DONE
module alu_stim_driver #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  opcode_valid,
    output logic                  opcode,
    output logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  overflow,
    input  logic                  done,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_timeout,
    output logic                  rsp_mismatch,
    output logic                  protocol_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_DONE,
        RESP
    } state_t;

    state_t                state;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH:0]   golden;

    // Reference result on zero-extended operands; the top bit is the carry
    // for add and the borrow for sub, always 0 for the logic ops.
    always_comb begin
        golden = '0;
        case (op_q)
            2'b00:   golden = {1'b0, a_q} + {1'b0, b_q};
            2'b01:   golden = {1'b0, a_q} - {1'b0, b_q};
            2'b10:   golden = {1'b0, a_q ^ b_q};
            default: golden = {1'b0, ~(a_q ^ b_q)};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt          <= '0;
            cmd_ready    <= 1'b1;
            opcode_valid <= 1'b0;
            opcode       <= 1'b0;
            data         <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
            rsp_mismatch <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            // done is only meaningful while waiting for it; flag it elsewhere
            protocol_err <= done && (state != WAIT_DONE);

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q         <= cmd_op;
                        a_q          <= cmd_a;
                        b_q          <= cmd_b;
                        cmd_ready    <= 1'b0;
                        opcode_valid <= 1'b1;
                        data         <= cmd_a;
                        opcode       <= cmd_op[0];
                        state        <= SEND_A;
                    end
                end
                SEND_A: begin
                    data   <= b_q;
                    opcode <= op_q[1];
                    state  <= SEND_B;
                end
                SEND_B: begin
                    opcode_valid <= 1'b0;
                    data         <= '0;
                    opcode       <= 1'b0;
                    cnt          <= CW'(1);
                    state        <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // done takes priority over an expiring counter
                    if (done) begin
                        rsp_result   <= result;
                        rsp_overflow <= overflow;
                        rsp_timeout  <= 1'b0;
                        rsp_mismatch <= (result != golden[DATA_WIDTH-1:0]) ||
                                        (overflow != golden[DATA_WIDTH]);
                        rsp_valid    <= 1'b1;
                        cnt          <= '0;
                        state        <= RESP;
                    end else if (cnt == TMO) begin
                        rsp_result   <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_timeout  <= 1'b1;
                        rsp_mismatch <= 1'b0;
                        rsp_valid    <= 1'b1;
                        cnt          <= '0;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    cmd_ready    <= 1'b1;
                    opcode_valid <= 1'b0;
                    rsp_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stim_driver.sv
module tb_alu_stim_driver;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          opcode_valid;
    logic          opcode;
    logic [DW-1:0] data;
    logic [DW-1:0] result = '0;
    logic          overflow = 1'b0;
    logic          done = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_result;
    logic          rsp_overflow;
    logic          rsp_timeout;
    logic          rsp_mismatch;
    logic          protocol_err;

    alu_stim_driver #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .opcode_valid(opcode_valid), .opcode(opcode), .data(data),
        .result(result), .overflow(overflow), .done(done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          ov;
        logic          tmo;
        logic          mis;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_rsp    = 0;
    int   n_perr   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: pops one expectation per accepted response
    always @(negedge clk) begin : mon
        rsp_t e;
        if (protocol_err) n_perr++;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_result",   rsp_result,   e.res);
                check("rsp_overflow", rsp_overflow, e.ov);
                check("rsp_timeout",  rsp_timeout,  e.tmo);
                check("rsp_mismatch", rsp_mismatch, e.mis);
                n_rsp++;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Checks both serial operand cycles; optionally injects done during SEND_A
    task automatic check_ops(input logic [1:0] op, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input bit spur);
        @(negedge clk);
        check("sa_valid",  opcode_valid, 1);
        check("sa_opcode", opcode, op[0]);
        check("sa_data",   data, a);
        if (spur) begin
            done = 1'b1;
            @(posedge clk);
            #1 done = 1'b0;
        end
        @(negedge clk);
        check("sb_valid",  opcode_valid, 1);
        check("sb_opcode", opcode, op[1]);
        check("sb_data",   data, b);
    endtask

    // Called at the first WAIT_DONE negedge; asserts done on cycle 'dly'
    task automatic respond(input int dly, input logic [DW-1:0] res, input logic ov);
        for (int i = 1; i < dly; i++) @(negedge clk);
        result   = res;
        overflow = ov;
        done     = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        logic [DW-1:0] held;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_outs", {opcode_valid, opcode, data, rsp_valid, rsp_result,
                             rsp_overflow, rsp_timeout, rsp_mismatch, protocol_err}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // add F0+20 = 0x110 -> 0x10, carry 1; DUT correct
        exp_q.push_back('{8'h10, 1'b1, 1'b0, 1'b0});
        send(2'b00, 8'hF0, 8'h20);
        check_ops(2'b00, 8'hF0, 8'h20, 1'b0);
        @(negedge clk);
        check("wait_valid", opcode_valid, 0);
        check("wait_data",  data, 0);
        respond(1, 8'h10, 1'b1);
        @(negedge clk);
        check("add_latency_rsp_valid", rsp_valid, 1);

        // sub 05-07 = 0x1FE -> 0xFE, borrow 1; DUT reports overflow 0
        exp_q.push_back('{8'hFE, 1'b0, 1'b0, 1'b1});
        send(2'b01, 8'h05, 8'h07);
        check_ops(2'b01, 8'h05, 8'h07, 1'b0);
        @(negedge clk);
        respond(1, 8'hFE, 1'b0);

        // xnor AA,0F with no done -> timeout after 8 WAIT_DONE cycles
        exp_q.push_back('{8'h00, 1'b0, 1'b1, 1'b0});
        send(2'b11, 8'hAA, 8'h0F);
        check_ops(2'b11, 8'hAA, 8'h0F, 1'b0);
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 30) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", n, 8);

        // xor 3C,FF = 0xC3 with response back-pressure
        exp_q.push_back('{8'hC3, 1'b0, 1'b0, 1'b0});
        send(2'b10, 8'h3C, 8'hFF);
        rsp_ready = 1'b0;
        check_ops(2'b10, 8'h3C, 8'hFF, 1'b0);
        @(negedge clk);
        respond(1, 8'hC3, 1'b0);
        held = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_rsp_result", rsp_result, held);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_cmd_ready", cmd_ready, 1);
        check("release_rsp_valid", rsp_valid, 0);

        // add 01+02 with a spurious done during SEND_A, real done on cycle 3
        exp_q.push_back('{8'h03, 1'b0, 1'b0, 1'b0});
        send(2'b00, 8'h01, 8'h02);
        check_ops(2'b00, 8'h01, 8'h02, 1'b1);
        check("perr_pulse_hi", protocol_err, 1);
        @(negedge clk);
        check("perr_pulse_lo", protocol_err, 0);
        respond(3, 8'h03, 1'b0);
        @(negedge clk);
        check("spur_rsp_valid", rsp_valid, 1);

        // reset held 2 cycles in SEND_B aborts the transaction
        send(2'b01, 8'h11, 8'h22);
        check_ops(2'b01, 8'h11, 8'h22, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_outs", {opcode_valid, opcode, data, rsp_valid, rsp_result,
                             rsp_overflow, rsp_timeout, rsp_mismatch, protocol_err}, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
        end

        @(posedge clk);
        check("rsp_count", n_rsp, 5);
        check("queue_empty", exp_q.size(), 0);
        check("perr_count", n_perr, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
